// File: rtl/atm_keypad_entry_pkg.sv
// Shared definitions for the ATM keypad entry front-end: key codes, operation codes,
// FSM state encodings and the per-transaction field record.
package atm_keypad_entry_pkg;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_WITHDRAW   = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

  typedef enum logic [2:0] {
    S_LANG = 3'd0,
    S_ACC  = 3'd1,
    S_PIN  = 3'd2,
    S_OP   = 3'd3,
    S_AMT  = 3'd4,
    S_NPIN = 3'd5,
    S_REQ  = 3'd6
  } state_t;

  typedef struct packed {
    logic        language;
    logic [3:0]  acc_num;
    logic        acc_set;
    logic [15:0] pin;
    logic [2:0]  pin_cnt;
    logic [2:0]  operation;
    logic [31:0] amount;
    logic [3:0]  amt_cnt;
    logic [15:0] new_pin;
    logic [2:0]  npin_cnt;
  } fields_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // BCD digits enter on the right so the first digit ends up in [15:12] after four keys.
  function automatic logic [15:0] bcd_shift(input logic [15:0] cur, input logic [3:0] d);
    return {cur[11:0], d};
  endfunction

endpackage

// File: rtl/atm_keypad_entry_timer.sv
// Inactivity timer: counts enabled idle cycles and flags expiry on the last one
// unless a key clears it in the same cycle.
module atm_keypad_entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  assign expire = enable && !clear && (count_r == LAST);

  // Idle counter; held while disabled so it only advances inside the entry states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear || expire) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad front-end: assembles language, account, PIN, operation and amount/new PIN
// from key strobes, then holds the request for the controller until acknowledged.
module atm_keypad_entry
  import atm_keypad_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMT_DIGITS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        req_ack,
  output logic        req_valid,
  output logic        language,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [2:0]  operation,
  output logic [31:0] amount,
  output logic [15:0] new_pin,
  output logic        entry_err,
  output logic        timeout,
  output logic [2:0]  phase
);

  localparam logic [3:0] AMT_LIM = 4'(AMT_DIGITS);

  state_t  state_r, state_n;
  fields_t f_r, f_n;
  logic    req_valid_r, err_r, err_n, tmo_r, tmo_n;
  logic    digit_s, enter_s, clr_s, cancel_s, tmr_en_s, expire_s;

  assign digit_s  = key_valid && is_digit(key_code);
  assign enter_s  = key_valid && (key_code == KEY_ENTER);
  assign clr_s    = key_valid && (key_code == KEY_CLEAR);
  assign cancel_s = key_valid && (key_code == KEY_CANCEL);
  assign tmr_en_s = (state_r == S_ACC) || (state_r == S_PIN) || (state_r == S_OP) ||
                    (state_r == S_AMT) || (state_r == S_NPIN);

  atm_keypad_entry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (key_valid),
    .enable (tmr_en_s),
    .expire (expire_s)
  );

  // Next state and field updates; cancel outranks timeout, which outranks ack and keys.
  always_comb begin
    state_n = state_r;
    f_n     = f_r;
    err_n   = 1'b0;
    tmo_n   = 1'b0;
    if (cancel_s) begin
      state_n = S_LANG;
      f_n     = '0;
    end else if (expire_s) begin
      state_n = S_LANG;
      f_n     = '0;
      tmo_n   = 1'b1;
    end else if (state_r == S_REQ) begin
      if (req_ack) begin
        state_n = S_LANG;
        f_n     = '0;
      end else begin
        state_n = S_REQ;
      end
    end else begin
      case (state_r)
        S_LANG: begin
          if (digit_s && (key_code <= 4'd1)) begin
            f_n.language = key_code[0];
            state_n      = S_ACC;
          end else if (digit_s || enter_s) begin
            err_n = 1'b1;
          end else begin
            err_n = 1'b0;
          end
        end
        S_ACC: begin
          if (digit_s) begin
            f_n.acc_num = key_code;
            f_n.acc_set = 1'b1;
          end else if (enter_s) begin
            if (f_r.acc_set) state_n = S_PIN;
            else             err_n   = 1'b1;
          end else if (clr_s) begin
            f_n.acc_num = 4'd0;
            f_n.acc_set = 1'b0;
          end else begin
            err_n = 1'b0;
          end
        end
        S_PIN: begin
          if (digit_s) begin
            if (f_r.pin_cnt < 3'd4) begin
              f_n.pin     = bcd_shift(f_r.pin, key_code);
              f_n.pin_cnt = f_r.pin_cnt + 3'd1;
            end else begin
              f_n.pin_cnt = f_r.pin_cnt;
            end
          end else if (enter_s) begin
            if (f_r.pin_cnt == 3'd4) state_n = S_OP;
            else                     err_n   = 1'b1;
          end else if (clr_s) begin
            f_n.pin     = 16'd0;
            f_n.pin_cnt = 3'd0;
          end else begin
            err_n = 1'b0;
          end
        end
        S_OP: begin
          if (digit_s) begin
            case (key_code)
              4'd3: begin f_n.operation = OP_BALANCE;    state_n = S_REQ;  end
              4'd4: begin f_n.operation = OP_WITHDRAW;   state_n = S_AMT;  end
              4'd5: begin f_n.operation = OP_DEPOSIT;    state_n = S_AMT;  end
              4'd6: begin f_n.operation = OP_CHANGE_PIN; state_n = S_NPIN; end
              default: err_n = 1'b1;
            endcase
          end else if (enter_s) begin
            err_n = 1'b1;
          end else if (clr_s) begin
            f_n.operation = 3'd0;
          end else begin
            err_n = 1'b0;
          end
        end
        S_AMT: begin
          if (digit_s) begin
            if (f_r.amt_cnt < AMT_LIM) begin
              f_n.amount  = (f_r.amount * 32'd10) + {28'd0, key_code};
              f_n.amt_cnt = f_r.amt_cnt + 4'd1;
            end else begin
              f_n.amt_cnt = f_r.amt_cnt;
            end
          end else if (enter_s) begin
            if (f_r.amount != 32'd0) state_n = S_REQ;
            else                     err_n   = 1'b1;
          end else if (clr_s) begin
            f_n.amount  = 32'd0;
            f_n.amt_cnt = 4'd0;
          end else begin
            err_n = 1'b0;
          end
        end
        S_NPIN: begin
          if (digit_s) begin
            if (f_r.npin_cnt < 3'd4) begin
              f_n.new_pin  = bcd_shift(f_r.new_pin, key_code);
              f_n.npin_cnt = f_r.npin_cnt + 3'd1;
            end else begin
              f_n.npin_cnt = f_r.npin_cnt;
            end
          end else if (enter_s) begin
            if (f_r.npin_cnt == 3'd4) state_n = S_REQ;
            else                      err_n   = 1'b1;
          end else if (clr_s) begin
            f_n.new_pin  = 16'd0;
            f_n.npin_cnt = 3'd0;
          end else begin
            err_n = 1'b0;
          end
        end
        default: begin
          state_n = S_LANG;
          f_n     = '0;
        end
      endcase
    end
  end

  // State, fields and status pulses; req_valid tracks entry into S_REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_LANG;
      f_r         <= '0;
      req_valid_r <= 1'b0;
      err_r       <= 1'b0;
      tmo_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      f_r         <= f_n;
      req_valid_r <= (state_n == S_REQ);
      err_r       <= err_n;
      tmo_r       <= tmo_n;
    end
  end

  assign req_valid = req_valid_r;
  assign language  = f_r.language;
  assign acc_num   = f_r.acc_num;
  assign pin       = f_r.pin;
  assign operation = f_r.operation;
  assign amount    = f_r.amount;
  assign new_pin   = f_r.new_pin;
  assign entry_err = err_r;
  assign timeout   = tmo_r;
  assign phase     = state_r;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: key strings drive whole entries, and each
// observation is compared against a hand-computed value.
module tb_atm_keypad_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        req_ack = 1'b0;
  logic        req_valid, language, entry_err, timeout;
  logic [3:0]  acc_num;
  logic [15:0] pin, new_pin;
  logic [2:0]  operation, phase;
  logic [31:0] amount;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  atm_keypad_entry #(.TIMEOUT_CYCLES(16), .AMT_DIGITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .req_ack   (req_ack),
    .req_valid (req_valid),
    .language  (language),
    .acc_num   (acc_num),
    .pin       (pin),
    .operation (operation),
    .amount    (amount),
    .new_pin   (new_pin),
    .entry_err (entry_err),
    .timeout   (timeout),
    .phase     (phase)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // 'E' ENTER, 'C' CLEAR, 'X' CANCEL, digits as themselves
  function automatic logic [3:0] key_of(input logic [7:0] c);
    case (c)
      8'h45:   return 4'hA;
      8'h43:   return 4'hB;
      8'h58:   return 4'hC;
      default: return 4'(c - 8'd48);
    endcase
  endfunction

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) press(key_of(s[i]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
  endtask

  initial begin
    idle(2);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_pin", 32'(pin), 32'd0);
    chk("rst_amount", amount, 32'd0);
    rst = 1'b1;
    idle(1);

    // invalid language digit
    keys("5");
    chk("lang_err", 32'(entry_err), 32'd1);
    chk("lang_phase", 32'(phase), 32'd0);

    // balance
    keys("07E1234E3");
    chk("bal_valid", 32'(req_valid), 32'd1);
    chk("bal_acc", 32'(acc_num), 32'd7);
    chk("bal_pin", 32'(pin), 32'h1234);
    chk("bal_op", 32'(operation), 32'd3);
    chk("bal_amount", amount, 32'd0);
    chk("bal_phase", 32'(phase), 32'd6);
    keys("5");
    chk("req_key_err", 32'(entry_err), 32'd0);
    chk("req_key_valid", 32'(req_valid), 32'd1);
    ack();
    chk("ack_valid", 32'(req_valid), 32'd0);
    chk("ack_phase", 32'(phase), 32'd0);
    chk("ack_pin", 32'(pin), 32'd0);

    // withdraw 250
    keys("12E5555E4250E");
    chk("wd_lang", 32'(language), 32'd1);
    chk("wd_op", 32'(operation), 32'd4);
    chk("wd_amount", amount, 32'd250);
    chk("wd_valid", 32'(req_valid), 32'd1);
    ack();

    // deposit: zero amount rejected, then digit limit
    keys("03E1111E5E");
    chk("amt0_err", 32'(entry_err), 32'd1);
    chk("amt0_phase", 32'(phase), 32'd4);
    keys("999999999");
    chk("amt_limit", amount, 32'd99_999_999);
    keys("E");
    chk("dep_op", 32'(operation), 32'd5);
    chk("dep_valid", 32'(req_valid), 32'd1);
    ack();

    // short PIN, clear, retry, then change PIN
    keys("01E12E");
    chk("pin_err", 32'(entry_err), 32'd1);
    chk("pin_phase", 32'(phase), 32'd2);
    idle(1);
    chk("pin_err_drop", 32'(entry_err), 32'd0);
    keys("C9876E");
    chk("pin_retry", 32'(pin), 32'h9876);
    chk("op_phase", 32'(phase), 32'd3);
    keys("7");
    chk("op_err", 32'(entry_err), 32'd1);
    keys("64321E");
    chk("cp_op", 32'(operation), 32'd6);
    chk("cp_newpin", 32'(new_pin), 32'h4321);
    chk("cp_amount", amount, 32'd0);
    chk("cp_valid", 32'(req_valid), 32'd1);
    ack();

    // inactivity timeout in S_AMT
    keys("01E1234E47");
    idle(15);
    chk("tmo_early", 32'(timeout), 32'd0);
    chk("tmo_early_phase", 32'(phase), 32'd4);
    idle(1);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_phase", 32'(phase), 32'd0);
    chk("tmo_amount", amount, 32'd0);
    chk("tmo_acc", 32'(acc_num), 32'd0);
    chk("tmo_err", 32'(entry_err), 32'd0);
    idle(1);
    chk("tmo_drop", 32'(timeout), 32'd0);

    // key on the last idle cycle wins
    keys("01E1234E47");
    idle(15);
    keys("8");
    chk("tmo_key_none", 32'(timeout), 32'd0);
    chk("tmo_key_amount", amount, 32'd78);
    chk("tmo_key_phase", 32'(phase), 32'd4);
    keys("X");
    chk("cancel_phase", 32'(phase), 32'd0);
    chk("cancel_amount", amount, 32'd0);

    // cancel and ack together in S_REQ
    keys("01E1234E3");
    key_valid = 1'b1;
    key_code  = 4'hC;
    req_ack   = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
    req_ack   = 1'b0;
    chk("ca_valid", 32'(req_valid), 32'd0);
    chk("ca_pin", 32'(pin), 32'd0);
    chk("ca_err", 32'(entry_err), 32'd0);
    chk("ca_phase", 32'(phase), 32'd0);

    // asynchronous reset mid-PIN
    keys("01E12");
    chk("pre_rst_pin", 32'(pin), 32'h0012);
    #2 rst = 1'b0;
    #1;
    chk("arst_pin", 32'(pin), 32'd0);
    chk("arst_acc", 32'(acc_num), 32'd0);
    chk("arst_phase", 32'(phase), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
